// File: rtl/systolic1x2_ctrl.sv
// systolic1x2_ctrl: job sequencer for the systolic1x2 multiply-accumulate array.
// Clears the array, streams K operand beats into it, waits for the pipeline to
// drain, then holds the captured accumulators behind a valid/ready handshake.
//
// Parameters:
//   KW     - width of the job length field (max K = 2^KW-1)
//   DRAIN  - cycles waited after the last accepted beat before capture (>= 3)
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   start, cfg_len            - job request and beat count K (IDLE only)
//   busy                      - high in every state except IDLE
//   in_valid/in_ready         - operand beat handshake
//   in_a0, in_a1, in_b0       - operand beat
//   arr_rst                   - array reset (rst or CLEAR state)
//   arr_a0, arr_a1, arr_b0    - registered array operands (a1 skewed one cycle)
//   arr_c0, arr_c1            - array accumulators
//   res_valid/res_ready       - result handshake
//   res_c0, res_c1            - captured results
// Optional feature (macro SYSTOLIC1X2_CTRL_CYCCNT_EN):
//   job_cycles                - saturating count of CLEAR/STREAM/DRAIN cycles

module systolic1x2_ctrl #(
    parameter int unsigned KW    = 5,
    parameter int unsigned DRAIN = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [KW-1:0] cfg_len,
    output logic          busy,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [15:0]   in_a0,
    input  logic [15:0]   in_a1,
    input  logic [15:0]   in_b0,
    output logic          arr_rst,
    output logic [15:0]   arr_a0,
    output logic [15:0]   arr_a1,
    output logic [15:0]   arr_b0,
    input  logic [31:0]   arr_c0,
    input  logic [31:0]   arr_c1,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [31:0]   res_c0,
    output logic [31:0]   res_c1
`ifdef SYSTOLIC1X2_CTRL_CYCCNT_EN
    ,
    output logic [15:0]   job_cycles
`endif
);

    localparam int unsigned OW  = 16;
    localparam int unsigned RW  = 32;
    localparam int unsigned DCW = (DRAIN > 1) ? $clog2(DRAIN) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } state_e;

    state_e          state_q;
    logic [KW-1:0]   len_q;
    logic [KW-1:0]   beat_cnt_q;
    logic [KW-1:0]   beat_cnt_d;
    logic [DCW-1:0]  drain_cnt_q;
    logic            busy_q;
    logic            in_ready_q;
    logic            res_valid_q;
    logic [RW-1:0]   res_c0_q;
    logic [RW-1:0]   res_c1_q;
    logic [OW-1:0]   arr_a0_q;
    logic [OW-1:0]   arr_a1_q;
    logic [OW-1:0]   arr_b0_q;
    logic [OW-1:0]   skew_q;
    logic            beat_acc;
    logic            beat_last;
    logic            drain_last;

    // Beat acceptance; in_ready_q is only ever set in STREAM.
    assign beat_acc   = in_valid & in_ready_q;
    assign beat_cnt_d = beat_cnt_q + KW'(1);
    assign beat_last  = (beat_cnt_d == len_q);
    assign drain_last = (drain_cnt_q == DCW'(DRAIN - 1));

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            beat_cnt_q  <= '0;
            drain_cnt_q <= '0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            res_valid_q <= 1'b0;
            res_c0_q    <= '0;
            res_c1_q    <= '0;
            arr_a0_q    <= '0;
            arr_a1_q    <= '0;
            arr_b0_q    <= '0;
            skew_q      <= '0;
        end else begin
            // The array accumulates every cycle, so non-beat cycles feed zeros.
            arr_a0_q <= beat_acc ? in_a0 : '0;
            arr_b0_q <= beat_acc ? in_b0 : '0;
            skew_q   <= beat_acc ? in_a1 : '0;
            // a1 lags one cycle to line up with the array's internal b pass-through.
            arr_a1_q <= skew_q;

            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q    <= ST_CLEAR;
                        len_q      <= cfg_len;
                        beat_cnt_q <= '0;
                        busy_q     <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    // K==0 skips straight to draining a cleared, unfed array.
                    if (len_q == '0) begin
                        state_q     <= ST_DRAIN;
                        drain_cnt_q <= '0;
                    end else begin
                        state_q    <= ST_STREAM;
                        in_ready_q <= 1'b1;
                        beat_cnt_q <= '0;
                    end
                end
                ST_STREAM: begin
                    if (beat_acc) begin
                        beat_cnt_q <= beat_cnt_d;
                        if (beat_last) begin
                            state_q     <= ST_DRAIN;
                            in_ready_q  <= 1'b0;
                            drain_cnt_q <= '0;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_last) begin
                        res_c0_q    <= arr_c0;
                        res_c1_q    <= arr_c1;
                        res_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end else begin
                        drain_cnt_q <= drain_cnt_q + DCW'(1);
                    end
                end
                ST_DONE: begin
                    // start is deliberately ignored here, even on the handshake cycle.
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    busy_q     <= 1'b0;
                    in_ready_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef SYSTOLIC1X2_CTRL_CYCCNT_EN
    logic [15:0] cyc_cnt_q;

    // Active-job cycle counter, saturating, held outside CLEAR/STREAM/DRAIN.
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_cnt_q <= '0;
        end else if (state_q == ST_IDLE && start) begin
            cyc_cnt_q <= '0;
        end else if ((state_q == ST_CLEAR || state_q == ST_STREAM || state_q == ST_DRAIN)
                     && cyc_cnt_q != 16'hFFFF) begin
            cyc_cnt_q <= cyc_cnt_q + 16'd1;
        end
    end

    assign job_cycles = cyc_cnt_q;
`endif

    // Array reset must follow rst in the same cycle, so it is a direct decode.
    assign arr_rst   = rst | (state_q == ST_CLEAR);
    assign busy      = busy_q;
    assign in_ready  = in_ready_q;
    assign res_valid = res_valid_q;
    assign res_c0    = res_c0_q;
    assign res_c1    = res_c1_q;
    assign arr_a0    = arr_a0_q;
    assign arr_a1    = arr_a1_q;
    assign arr_b0    = arr_b0_q;

endmodule
